otprom_prog_ctrl: RTL and testbench

Programming controller for the OTPROM. It sits directly upstream of the OTPROM access agent and drives the agent's master RAM port (`m_ram_*`). It accepts single-word burn requests and issues a read-modify-write that only ever sets bits. It holds the write for a fixed burn time, then verifies by readback with bounded retries and returns one status pulse per request.

---
 rtl/otprom_prog_ctrl_pkg.sv | 20 ++
 rtl/otprom_prog_ctrl_if.sv | 26 ++
 rtl/otprom_burn_timer.sv | 22 ++
 rtl/otprom_prog_ctrl.sv | 143 ++++++++++++++
 tb/tb_otprom_prog_ctrl.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/otprom_prog_ctrl_pkg.sv
// Shared widths, FSM encoding and status codes for the OTPROM programming controller.
// The agent and the software-facing registers import the same status codes.
package otprom_prog_ctrl_pkg;
  localparam int OTP_BUS_WIDTH  = 16;
  localparam int OTP_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_CHECK  = 3'd2,
    S_BURN   = 3'd3,
    S_VRD    = 3'd4,
    S_VERIFY = 3'd5,
    S_RESP   = 3'd6
  } otp_state_e;

  localparam logic [1:0] OTP_ST_OK       = 2'b00;
  localparam logic [1:0] OTP_ST_DISABLED = 2'b01;
  localparam logic [1:0] OTP_ST_VFAIL    = 2'b10;
endpackage

// File: rtl/otprom_prog_ctrl_if.sv
// Request/response handshake between a burn requester (master) and the controller (slave).
interface otprom_prog_ctrl_if
  import otprom_prog_ctrl_pkg::*;
#(
  parameter int BUS_WIDTH  = OTP_BUS_WIDTH,
  parameter int DATA_WIDTH = OTP_DATA_WIDTH
);
  logic                  prog_enable;
  logic                  req_valid;
  logic                  req_ready;
  logic [BUS_WIDTH-1:0]  req_addr;
  logic [DATA_WIDTH-1:0] req_data;
  logic                  rsp_valid;
  logic [1:0]            rsp_status;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  busy;

  modport master (
    output prog_enable, req_valid, req_addr, req_data,
    input  req_ready, rsp_valid, rsp_status, rsp_rdata, busy
  );
  modport slave (
    input  prog_enable, req_valid, req_addr, req_data,
    output req_ready, rsp_valid, rsp_status, rsp_rdata, busy
  );
endinterface

// File: rtl/otprom_burn_timer.sv
// Loadable down-counter timing one burn attempt; done marks the final write-enable cycle.
module otprom_burn_timer #(
  parameter int BURN_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic done
);
  localparam logic [3:0] LOAD_VAL = 4'(BURN_CYCLES);

  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)                 cnt <= '0;
    else if (load)             cnt <= LOAD_VAL;
    else if (en && cnt != '0)  cnt <= cnt - 4'd1;
  end

  assign done = en && (cnt == 4'd1);
endmodule

// File: rtl/otprom_prog_ctrl.sv
// OTPROM burn controller: read-modify-write that only sets bits, timed burn,
// readback verify with bounded retries, one status pulse per request.
module otprom_prog_ctrl
  import otprom_prog_ctrl_pkg::*;
#(
  parameter int BUS_WIDTH   = OTP_BUS_WIDTH,
  parameter int DATA_WIDTH  = OTP_DATA_WIDTH,
  parameter int BURN_CYCLES = 4,
  parameter int MAX_RETRY   = 2,
  parameter int BOOT_HOLD   = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  otprom_prog_ctrl_if.slave       req_if,
  output logic [BUS_WIDTH-1:0]    m_ram_raddr,
  output logic                    m_ram_ren,
  input  logic [DATA_WIDTH-1:0]   m_ram_rdata,
  output logic [BUS_WIDTH-1:0]    m_ram_waddr,
  output logic [DATA_WIDTH-1:0]   m_ram_wdata,
  output logic [DATA_WIDTH/8-1:0] m_ram_wen
);
  localparam logic [7:0] BOOT_HOLD_C = 8'(BOOT_HOLD);
  localparam logic [1:0] MAX_RETRY_C = 2'(MAX_RETRY);

  otp_state_e            state;
  logic [7:0]            boot_cnt, boot_nxt;
  logic [BUS_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [1:0]            retry_q;
  logic                  need_burn, verify_ok, can_retry, boot_nxt_done;
  logic                  t_load, t_done;

  // Boot counter saturates; ready must be computed from its post-edge value.
  assign boot_nxt      = (boot_cnt == BOOT_HOLD_C) ? boot_cnt : boot_cnt + 8'd1;
  assign boot_nxt_done = (boot_nxt == BOOT_HOLD_C);

  assign need_burn = |(data_q & ~m_ram_rdata);
  assign verify_ok = ((m_ram_rdata & data_q) == data_q);
  assign can_retry = (retry_q < MAX_RETRY_C);
  assign t_load    = ((state == S_CHECK) && need_burn) ||
                     ((state == S_VERIFY) && !verify_ok && can_retry);

  otprom_burn_timer #(.BURN_CYCLES(BURN_CYCLES)) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (t_load),
    .en    (state == S_BURN),
    .done  (t_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= S_IDLE;
      boot_cnt          <= '0;
      addr_q            <= '0;
      data_q            <= '0;
      retry_q           <= '0;
      req_if.req_ready  <= 1'b0;
      req_if.rsp_valid  <= 1'b0;
      req_if.rsp_status <= OTP_ST_OK;
      req_if.rsp_rdata  <= '0;
      req_if.busy       <= 1'b0;
      m_ram_ren         <= 1'b0;
      m_ram_raddr       <= '0;
      m_ram_wen         <= '0;
      m_ram_waddr       <= '0;
      m_ram_wdata       <= '0;
    end else begin
      boot_cnt         <= boot_nxt;
      req_if.rsp_valid <= 1'b0;
      m_ram_ren        <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_if.req_valid && req_if.req_ready) begin
            addr_q           <= req_if.req_addr;
            data_q           <= req_if.req_data;
            retry_q          <= '0;
            req_if.req_ready <= 1'b0;
            req_if.busy      <= 1'b1;
            if (req_if.prog_enable) begin
              state       <= S_READ;
              m_ram_ren   <= 1'b1;
              m_ram_raddr <= req_if.req_addr;
            end else begin
              state             <= S_RESP;
              req_if.rsp_valid  <= 1'b1;
              req_if.rsp_status <= OTP_ST_DISABLED;
            end
          end else begin
            req_if.req_ready <= boot_nxt_done;
          end
        end
        S_READ: state <= S_CHECK;
        S_CHECK: begin
          if (need_burn) begin
            state       <= S_BURN;
            m_ram_wen   <= '1;
            m_ram_waddr <= addr_q;
            m_ram_wdata <= m_ram_rdata | data_q;
          end else begin
            state             <= S_RESP;
            req_if.rsp_valid  <= 1'b1;
            req_if.rsp_status <= OTP_ST_OK;
            req_if.rsp_rdata  <= m_ram_rdata;
          end
        end
        S_BURN: begin
          if (t_done) begin
            state       <= S_VRD;
            m_ram_wen   <= '0;
            m_ram_ren   <= 1'b1;
            m_ram_raddr <= addr_q;
          end
        end
        S_VRD: state <= S_VERIFY;
        S_VERIFY: begin
          req_if.rsp_rdata <= m_ram_rdata;
          if (verify_ok) begin
            state             <= S_RESP;
            req_if.rsp_valid  <= 1'b1;
            req_if.rsp_status <= OTP_ST_OK;
          end else if (can_retry) begin
            // Re-burn on top of what actually stuck, never clearing a set bit.
            state       <= S_BURN;
            retry_q     <= retry_q + 2'd1;
            m_ram_wen   <= '1;
            m_ram_wdata <= m_ram_rdata | data_q;
          end else begin
            state             <= S_RESP;
            req_if.rsp_valid  <= 1'b1;
            req_if.rsp_status <= OTP_ST_VFAIL;
          end
        end
        S_RESP: begin
          state            <= S_IDLE;
          req_if.busy      <= 1'b0;
          req_if.req_ready <= boot_nxt_done;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_otprom_prog_ctrl.sv
// Directed bench for otprom_prog_ctrl with a small behavioural OTPROM RAM model.
module tb_otprom_prog_ctrl;
  logic        clk;
  logic        reset;
  logic [15:0] m_ram_raddr, m_ram_waddr;
  logic        m_ram_ren;
  logic [31:0] m_ram_rdata, m_ram_wdata;
  logic [3:0]  m_ram_wen;

  logic [31:0] mem [256];
  logic        ignore_30;
  logic        pre_we;
  logic [7:0]  pre_addr;
  logic [31:0] pre_data;

  int n_checks, n_fail;

  otprom_prog_ctrl_if #(.BUS_WIDTH(16), .DATA_WIDTH(32)) rif ();

  otprom_prog_ctrl #(
    .BUS_WIDTH(16), .DATA_WIDTH(32), .BURN_CYCLES(4), .MAX_RETRY(2), .BOOT_HOLD(2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_if      (rif),
    .m_ram_raddr (m_ram_raddr),
    .m_ram_ren   (m_ram_ren),
    .m_ram_rdata (m_ram_rdata),
    .m_ram_waddr (m_ram_waddr),
    .m_ram_wdata (m_ram_wdata),
    .m_ram_wen   (m_ram_wen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: read data one cycle after ren; address 0x30 can be made unburnable.
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    if (m_ram_ren) m_ram_rdata <= mem[m_ram_raddr[7:0]];
    if (m_ram_wen != 4'h0 && !(ignore_30 && m_ram_waddr == 16'h0030))
      mem[m_ram_waddr[7:0]] <= m_ram_wdata;
  end

  task automatic poke(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Issue one request; report response cycle (relative to acceptance) and port activity.
  task automatic do_req(input logic [15:0] a, input logic [31:0] d, input logic pe,
                        input logic [31:0] exp_w, output int cyc, output logic [1:0] st,
                        output logic [31:0] rd, output int wcyc, output int rcyc,
                        output int bursts, output int bad);
    int  t;
    logic prev_w;
    cyc = -1; st = 2'bxx; rd = 'x; wcyc = 0; rcyc = 0; bursts = 0; bad = 0; prev_w = 1'b0;
    @(negedge clk);
    rif.req_valid = 1'b1; rif.req_addr = a; rif.req_data = d; rif.prog_enable = pe;
    t = 0;
    while (rif.req_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin rif.req_valid = 1'b0; return; end
    @(negedge clk);
    rif.req_valid = 1'b0;
    for (int c = 1; c < 60; c++) begin
      if (m_ram_wen != 4'h0) begin
        wcyc++;
        if (!prev_w) bursts++;
        if (m_ram_wen !== 4'hF || m_ram_wdata !== exp_w || m_ram_waddr !== a) bad++;
      end
      if (m_ram_ren) begin
        rcyc++;
        if (m_ram_raddr !== a) bad++;
        if (m_ram_wen != 4'h0) bad++;
      end
      prev_w = (m_ram_wen != 4'h0);
      if (rif.rsp_valid === 1'b1) begin
        cyc = c; st = rif.rsp_status; rd = rif.rsp_rdata;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rif.req_valid = 1'b0; rif.prog_enable = 1'b0; rif.req_addr = '0; rif.req_data = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (rif.req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", rif.req_ready); end
    n_checks++; if (rif.busy !== 1'b0 || rif.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_busy_rsp got %b%b want 00", rif.busy, rif.rsp_valid); end
    n_checks++; if (m_ram_ren !== 1'b0 || m_ram_wen !== 4'h0) begin n_fail++; $display("FAIL reset_ren_wen got %b %h want 0 0", m_ram_ren, m_ram_wen); end
    n_checks++; if (m_ram_wdata !== 32'h0 || rif.rsp_status !== 2'b00 || rif.rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h %b %h want 0", m_ram_wdata, rif.rsp_status, rif.rsp_rdata); end
    // Release reset with a request already pending.
    reset = 1'b0;
    rif.req_valid = 1'b1; rif.prog_enable = 1'b0; rif.req_addr = 16'h0010; rif.req_data = 32'h1;
    n_checks++; if (rif.req_ready !== 1'b0) begin n_fail++; $display("FAIL boot_c0_ready got %b want 0", rif.req_ready); end
    @(negedge clk);
    n_checks++; if (rif.req_ready !== 1'b0) begin n_fail++; $display("FAIL boot_c1_ready got %b want 0", rif.req_ready); end
    @(negedge clk);
    n_checks++; if (rif.req_ready !== 1'b1) begin n_fail++; $display("FAIL boot_c2_ready got %b want 1", rif.req_ready); end
    @(negedge clk);
    rif.req_valid = 1'b0;
    n_checks++; if (rif.rsp_valid !== 1'b1 || rif.rsp_status !== 2'b01) begin n_fail++; $display("FAIL boot_first_rsp got %b/%b want 1/01", rif.rsp_valid, rif.rsp_status); end
    n_checks++; if (rif.req_ready !== 1'b0) begin n_fail++; $display("FAIL boot_rsp_ready got %b want 0", rif.req_ready); end
    @(negedge clk);
    n_checks++; if (rif.req_ready !== 1'b1 || rif.busy !== 1'b0) begin n_fail++; $display("FAIL boot_idle got ready %b busy %b want 1 0", rif.req_ready, rif.busy); end
  endtask

  task automatic test_single_burn();
    int cyc, wc, rc, bu, bad; logic [1:0] st; logic [31:0] rd;
    poke(8'h20, 32'h0);
    do_req(16'h0020, 32'h05, 1'b1, 32'h05, cyc, st, rd, wc, rc, bu, bad);
    n_checks++; if (cyc !== 9) begin n_fail++; $display("FAIL burn_latency got %0d want 9", cyc); end
    n_checks++; if (st !== 2'b00 || rd !== 32'h05) begin n_fail++; $display("FAIL burn_rsp got %b/%h want 00/05", st, rd); end
    n_checks++; if (wc !== 4 || bu !== 1 || rc !== 2 || bad !== 0) begin n_fail++; $display("FAIL burn_port got wen %0d bursts %0d ren %0d bad %0d want 4 1 2 0", wc, bu, rc, bad); end
    n_checks++; if (rif.req_ready !== 1'b0) begin n_fail++; $display("FAIL burn_rsp_ready got %b want 0", rif.req_ready); end
  endtask

  task automatic test_nothing_to_burn();
    int cyc, wc, rc, bu, bad; logic [1:0] st; logic [31:0] rd;
    do_req(16'h0020, 32'h04, 1'b1, 32'h0, cyc, st, rd, wc, rc, bu, bad);
    n_checks++; if (cyc !== 3) begin n_fail++; $display("FAIL noburn_latency got %0d want 3", cyc); end
    n_checks++; if (st !== 2'b00 || rd !== 32'h05) begin n_fail++; $display("FAIL noburn_rsp got %b/%h want 00/05", st, rd); end
    n_checks++; if (wc !== 0 || rc !== 1 || bad !== 0) begin n_fail++; $display("FAIL noburn_port got wen %0d ren %0d bad %0d want 0 1 0", wc, rc, bad); end
    do_req(16'h0020, 32'h0, 1'b1, 32'h0, cyc, st, rd, wc, rc, bu, bad);
    n_checks++; if (cyc !== 3 || st !== 2'b00 || wc !== 0) begin n_fail++; $display("FAIL zero_data got cyc %0d st %b wen %0d want 3 00 0", cyc, st, wc); end
  endtask

  task automatic test_disabled();
    int cyc, wc, rc, bu, bad; logic [1:0] st; logic [31:0] rd;
    do_req(16'h0010, 32'h01, 1'b0, 32'h0, cyc, st, rd, wc, rc, bu, bad);
    n_checks++; if (cyc !== 1 || st !== 2'b01) begin n_fail++; $display("FAIL disabled_rsp got cyc %0d st %b want 1 01", cyc, st); end
    n_checks++; if (wc !== 0 || rc !== 0) begin n_fail++; $display("FAIL disabled_port got wen %0d ren %0d want 0 0", wc, rc); end
  endtask

  task automatic test_preserve_bits();
    int cyc, wc, rc, bu, bad; logic [1:0] st; logic [31:0] rd;
    poke(8'h40, 32'hA0);
    do_req(16'h0040, 32'h05, 1'b1, 32'hA5, cyc, st, rd, wc, rc, bu, bad);
    n_checks++; if (cyc !== 9 || st !== 2'b00 || rd !== 32'hA5 || bad !== 0) begin n_fail++; $display("FAIL preserve got cyc %0d st %b rd %h bad %0d want 9 00 a5 0", cyc, st, rd, bad); end
  endtask

  task automatic test_verify_fail();
    int cyc, wc, rc, bu, bad; logic [1:0] st; logic [31:0] rd;
    poke(8'h30, 32'h0);
    ignore_30 = 1'b1;
    do_req(16'h0030, 32'h80, 1'b1, 32'h80, cyc, st, rd, wc, rc, bu, bad);
    ignore_30 = 1'b0;
    n_checks++; if (cyc !== 21) begin n_fail++; $display("FAIL vfail_latency got %0d want 21", cyc); end
    n_checks++; if (st !== 2'b10 || rd !== 32'h0) begin n_fail++; $display("FAIL vfail_rsp got %b/%h want 10/0", st, rd); end
    n_checks++; if (bu !== 3 || wc !== 12 || rc !== 4 || bad !== 0) begin n_fail++; $display("FAIL vfail_port got bursts %0d wen %0d ren %0d bad %0d want 3 12 4 0", bu, wc, rc, bad); end
  endtask

  task automatic test_back_to_back();
    int cyc, wc, rc, bu, bad; logic [1:0] st; logic [31:0] rd;
    do_req(16'h0011, 32'h1, 1'b0, 32'h0, cyc, st, rd, wc, rc, bu, bad);
    @(negedge clk);
    n_checks++; if (rif.req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got %b want 1", rif.req_ready); end
    rif.req_valid = 1'b1; rif.prog_enable = 1'b0; rif.req_addr = 16'h0012; rif.req_data = 32'h2;
    @(negedge clk);
    rif.req_valid = 1'b0;
    n_checks++; if (rif.rsp_valid !== 1'b1 || rif.rsp_status !== 2'b01) begin n_fail++; $display("FAIL b2b_rsp got %b/%b want 1/01", rif.rsp_valid, rif.rsp_status); end
  endtask

  task automatic test_reset_mid_burn();
    int t; int rsp_seen;
    poke(8'h50, 32'h0);
    @(negedge clk);
    rif.req_valid = 1'b1; rif.prog_enable = 1'b1; rif.req_addr = 16'h0050; rif.req_data = 32'h1;
    t = 0;
    while (rif.req_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    @(negedge clk);
    rif.req_valid = 1'b0;
    t = 0;
    while (m_ram_wen == 4'h0 && t < 50) begin @(negedge clk); t++; end
    n_checks++; if (t >= 50) begin n_fail++; $display("FAIL midrst_burn_start got timeout want wen"); end
    @(negedge clk);
    n_checks++; if (m_ram_wen !== 4'hF) begin n_fail++; $display("FAIL midrst_2nd_burn got %h want f", m_ram_wen); end
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (m_ram_wen !== 4'h0 || rif.busy !== 1'b0 || rif.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_abort got wen %h busy %b rsp %b want 0 0 0", m_ram_wen, rif.busy, rif.rsp_valid); end
    reset = 1'b0;
    rsp_seen = 0;
    n_checks++; if (rif.req_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_hold0 got %b want 0", rif.req_ready); end
    if (rif.rsp_valid) rsp_seen++;
    @(negedge clk);
    n_checks++; if (rif.req_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_hold1 got %b want 0", rif.req_ready); end
    if (rif.rsp_valid) rsp_seen++;
    @(negedge clk);
    n_checks++; if (rif.req_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_hold2 got %b want 1", rif.req_ready); end
    if (rif.rsp_valid) rsp_seen++;
    n_checks++; if (rsp_seen !== 0) begin n_fail++; $display("FAIL midrst_no_rsp got %0d want 0", rsp_seen); end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    ignore_30 = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    test_reset();
    test_single_burn();
    test_nothing_to_burn();
    test_disabled();
    test_preserve_bits();
    test_verify_fail();
    test_back_to_back();
    test_reset_mid_burn();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
